// File: rtl/pipe_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states
// and a sign-magnitude helper.
package pipe_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Radix-2 iteration count equals the operand width.
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/pipe_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the remainder,
// subtract the divisor, keep the difference only if it did not go negative.
module pipe_div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvsr_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {2'b00, dvsr_i};
    if (!diff[33]) begin
      rem_o = diff[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[32:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning architectural HI/LO, with MTHI/MTLO writes
// and an MFHI/MFLO stall while an operation is in flight.
module pipe_muldiv_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  // Handshake: a request transfers on a rising edge where op_valid && op_ready;
  // op_ready depends only on state, and op_a/op_b are sampled at that edge only.
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic        busy,
  input  logic        mf_req,
  output logic        mf_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic [1:0]  dbg_state
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        mul_sgn_q, mul_sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic [63:0] ext_a, ext_b, product;
  logic        div_sgn;

  pipe_div_step u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Extending to 64 bits before multiplying gives the exact low 64 bits for both signednesses.
  assign ext_a   = mul_sgn_q ? {{32{mul_a_q[31]}}, mul_a_q} : {32'b0, mul_a_q};
  assign ext_b   = mul_sgn_q ? {{32{mul_b_q[31]}}, mul_b_q} : {32'b0, mul_b_q};
  assign product = ext_a * ext_b;
  assign div_sgn = (op_code == MD_DIV);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_sgn_d = mul_sgn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            MD_MULT, MD_MULTU: begin
              mul_a_d   = op_a;
              mul_b_d   = op_b;
              mul_sgn_d = (op_code == MD_MULT);
              cnt_d     = 5'(MUL_LATENCY - 1);
              state_d   = MUL;
            end
            MD_DIV, MD_DIVU: begin
              rem_d   = '0;
              quo_d   = mag32(op_a, div_sgn);
              dvsr_d  = mag32(op_b, div_sgn);
              // A zero divisor keeps an all-ones quotient so LO reads 0xFFFFFFFF either way.
              qneg_d  = div_sgn && (op_a[31] ^ op_b[31]) && (op_b != 32'd0);
              rneg_d  = div_sgn && op_a[31];
              cnt_d   = 5'(DIV_STEPS - 1);
              state_d = DIV;
            end
            MD_MTHI: hi_d = op_a;
            MD_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q[31:0] : rem_q[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_sgn_q <= mul_sgn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mf_stall  = mf_req & busy;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Self-checking bench for pipe_muldiv_ctrl: directed corner cases plus random ops
// checked against an arithmetic HI/LO model with a latency/busy expectation.
module tb_pipe_muldiv_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        op_ready, busy, mf_req, mf_stall, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] exp_q[$];

  pipe_muldiv_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy),
    .mf_req(mf_req), .mf_stall(mf_stall), .hi(hi), .lo(lo), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Architectural result {hi,lo} from the ISA definition, given current HI/LO.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [31:0] h0, l0);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, l0};
      3'd5: return {h0, a};
      default: return {h0, l0};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return L;
    if (op <= 3'd3) return 33;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input bit immediate);
    logic [63:0] e;
    int lat, n;
    bit hold_ok, stall_ok;
    if (!immediate) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL done_width: done=%b required 0", done); end
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL ready_idle: op_ready=%b required 1", op_ready); end
    exp_q.push_back(model(op, a, b, m_hi, m_lo));
    lat = latency(op);
    op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_code = 3'($urandom_range(0, 7));
    n = 0; hold_ok = 1'b1; stall_ok = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0 || op_ready !== 1'b0) hold_ok = 1'b0;
      if (mf_stall !== mf_req) stall_ok = 1'b0;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (n != lat) begin n_bad++; $display("FAIL latency op%0d: busy %0d cycles required %0d", op, n, lat); end
    n_cmp++;
    if (!hold_ok) begin n_bad++; $display("FAIL hold op%0d: outputs changed while busy, required stable", op); end
    n_cmp++;
    if (!stall_ok || mf_stall !== 1'b0) begin
      n_bad++; $display("FAIL mf_stall op%0d: stall=%b req=%b required mf_req&busy", op, mf_stall, mf_req);
    end
    n_cmp++;
    if (hi !== e[63:32] || lo !== e[31:0]) begin
      n_bad++;
      $display("FAIL result op%0d a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h",
               op, a, b, hi, lo, e[63:32], e[31:0]);
    end
    n_cmp++;
    if (done !== (lat != 0)) begin
      n_bad++; $display("FAIL done_pulse op%0d: done=%b required %b", op, done, lat != 0);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; mf_req = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || busy !== 1'b0 ||
        op_ready !== 1'b1 || mf_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h done=%b busy=%b ready=%b stall=%b required 0/0/0/0/1/0",
               hi, lo, done, busy, op_ready, mf_stall);
    end
    mf_req = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1);
    run_op(3'd0, 32'h80000000, 32'h80000000, 1'b1);
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    run_op(3'd3, 32'd100, 32'd7, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_op(3'd3, 32'd5, 32'd0, 1'b0);
    run_op(3'd2, 32'hFFFFFFF7, 32'd0, 1'b0);
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 1'b0);
  endtask

  task automatic test_mt();
    run_op(3'd4, 32'hCAFEF00D, 32'd0, 1'b0);
    run_op(3'd5, 32'h0BADBEEF, 32'd0, 1'b1);
    run_op(3'd6, 32'h11111111, 32'd3, 1'b1);
    run_op(3'd7, 32'h22222222, 32'd3, 1'b0);
  endtask

  task automatic test_mf_stall();
    mf_req = 1'b1;
    run_op(3'd2, 32'd1000, 32'hFFFFFFFD, 1'b0);
    run_op(3'd1, 32'd12345, 32'd678, 1'b0);
    mf_req = 1'b0;
  endtask

  task automatic test_busy_accept();
    logic [63:0] e;
    int n;
    @(negedge clk);
    e = model(3'd3, 32'd1000, 32'd3, m_hi, m_lo);
    op_valid = 1'b1; op_code = 3'd3; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    op_code = 3'd5; op_a = 32'h00001234; op_b = 32'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    n_cmp++;
    if (n != 33) begin n_bad++; $display("FAIL held_latency: busy %0d cycles required 33", n); end
    n_cmp++;
    if (lo !== e[31:0] || hi !== e[63:32] || done !== 1'b1) begin
      n_bad++;
      $display("FAIL held_early: hi=%h lo=%h done=%b required hi=%h lo=%h done=1", hi, lo, done, e[63:32], e[31:0]);
    end
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if (lo !== 32'h00001234 || hi !== e[63:32] || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_mtlo: hi=%h lo=%h busy=%b required hi=%h lo=00001234 busy=0", hi, lo, busy, e[63:32]);
    end
    m_hi = e[63:32]; m_lo = 32'h00001234;
  endtask

  task automatic test_reset_abort();
    int bad;
    run_op(3'd4, 32'hDEAD0001, 32'd0, 1'b0);
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd2; op_a = 32'd99999; op_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_reset: hi=%h lo=%h ready=%b busy=%b done=%b required 0/0/1/0/0",
               hi, lo, op_ready, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL abort_quiet: %0d bad cycles required 0", bad); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      mf_req = 1'($urandom_range(0, 1));
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end
    mf_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_mf_stall();
    test_busy_accept();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
